axi_aw_rr_scheduler: RTL
========================

AXI_AW_RR_SCHEDULER -- requirements
Module: axi_aw_rr_scheduler

Interface
REQ-001 SHALL have parameter N_TARG_PORT, default 7, number of write-address requesters.
REQ-002 SHALL have parameter LOG_N_TARG, default $clog2(N_TARG_PORT), binary index width.
REQ-003 SHALL have parameter AW_PAYLOAD_W, default 64, packed AW payload width (addr, id, len, size, burst, user).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8, maximum bursts granted whose write data is not yet complete.
REQ-005 SHALL have port clk  input  1  clock; one clock domain, all state on the rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port awvalid_i  input  N_TARG_PORT  per-requester AW valid.
REQ-008 SHALL have port awpayload_i  input  N_TARG_PORT x AW_PAYLOAD_W  per-requester AW payload.
REQ-009 SHALL have port awready_o  output  N_TARG_PORT  per-requester AW ready.
REQ-010 SHALL have port awvalid_o  output  1  downstream AW valid.
REQ-011 SHALL have port awpayload_o  output  AW_PAYLOAD_W  payload of the current winner.
REQ-012 SHALL have port awready_i  input  1  downstream AW ready.
REQ-013 SHALL have port push_ID_o  output  1  push strobe to the write-data allocator ID FIFO.
REQ-014 SHALL have port ID_o  output  LOG_N_TARG+N_TARG_PORT  {binary winner, one-hot winner}.
REQ-015 SHALL have port grant_FIFO_ID_i  input  1  ID FIFO not full.
REQ-016 SHALL have port wburst_done_i  input  1  one-cycle pulse per completed write burst (wvalid&wready&wlast downstream).
REQ-017 SHALL have port outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current outstanding-burst count.

Function
REQ-018 SHALL implement FSM states IDLE and LOCKED, plus registers rr_ptr (LOG_N_TARG bits), winner (LOG_N_TARG bits) and cnt.
REQ-019 IDLE: eligible = (|awvalid_i) & grant_FIFO_ID_i & (cnt < MAX_OUTSTANDING).
REQ-020 IDLE, eligible: winner = first index with awvalid_i set, searching rr_ptr, rr_ptr+1, ... modulo N_TARG_PORT, selected combinationally.
REQ-021 IDLE, eligible: awvalid_o SHALL assert in the same cycle (zero-cycle latency).
REQ-022 IDLE, not eligible: awvalid_o=0, awready_o=0, push_ID_o=0, next state IDLE.
REQ-023 IDLE, eligible & !awready_i: store winner and go to LOCKED.
REQ-024 LOCKED: awvalid_o=1 and the winner stays frozen until awready_i, ignoring grant_FIFO_ID_i and cnt; both can only relax while this block does not push.
REQ-025 awpayload_o SHALL be awpayload_i[winner]; when awvalid_o=0 it is don't-care.
REQ-026 awready_o[k] = awvalid_o & awready_i & (k == winner); at most one bit SHALL be set.
REQ-027 push_ID_o = awvalid_o & awready_i; ID_o = {winner binary, one-hot(winner)} whenever push_ID_o=1.
REQ-028 On handshake: rr_ptr <= (winner == N_TARG_PORT-1) ? 0 : winner+1; next state IDLE.
REQ-029 Back-to-back grants SHALL be possible: a handshake in IDLE allows a new grant in the following cycle.
REQ-030 cnt: +1 on push_ID_o only, -1 on wburst_done_i only, unchanged when both occur in the same cycle.
REQ-031 wburst_done_i with cnt==0 and no push SHALL be ignored; cnt never wraps below 0 or above MAX_OUTSTANDING.
REQ-032 outstanding_o = cnt.
REQ-033 If the winner drops awvalid_i while LOCKED (protocol violation), awvalid_o SHALL still hold 1 and payload tracks the input.

Reset
REQ-034 While rst=1 at a rising edge: state<=IDLE, rr_ptr<=0, winner<=0, cnt<=0.
REQ-035 Reset mid-LOCKED SHALL abandon the pending grant; the cycle after reset deasserts, all outputs are driven from the IDLE rules.
REQ-036 While rst=1, awvalid_o, awready_o, push_ID_o and outstanding_o SHALL be 0.

Verification
REQ-037 All 7 awvalid_i=1, awready_i=1, grant_FIFO_ID_i=1, wburst_done_i each cycle -> grants 0,1,...,6,0 on consecutive cycles; ID_o for port 3 = {3'd3, 7'b0001000}.
REQ-038 Port 2 requests with awready_i=0 for 4 cycles, port 0 raises awvalid_i in cycle 2 -> awvalid_o held 4 cycles, winner stays 2, payload stable; handshake in cycle 5, then port 0 is granted.
REQ-039 grant_FIFO_ID_i=0 with requests pending -> awvalid_o=0, no push; raising it -> grant in the same cycle.
REQ-040 9 grants, no wburst_done_i, MAX_OUTSTANDING=8 -> 8 pushes, outstanding_o=8, awvalid_o=0; one wburst_done_i -> the 9th grant next cycle.
REQ-041 push_ID_o and wburst_done_i in the same cycle at cnt=3 -> cnt stays 3; wburst_done_i at cnt=0 -> cnt stays 0.
REQ-042 rst=1 for one cycle while LOCKED on port 5 -> next cycle state IDLE, rr_ptr=0, port 0 wins if requesting.

Source files
------------

// File: rtl/axi_aw_rr_scheduler.sv
// Round-robin arbiter for AXI write-address channels. The grant is combinational in IDLE
// and frozen in LOCKED until the downstream accepts. Outstanding write bursts are capped.
module axi_aw_rr_scheduler #(
  parameter int N_TARG_PORT     = 7,
  parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W    = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_TARG_PORT-1:0]                    awvalid_i,
  input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0]  awpayload_i,
  output logic [N_TARG_PORT-1:0]                    awready_o,
  output logic                                      awvalid_o,
  output logic [AW_PAYLOAD_W-1:0]                   awpayload_o,
  input  logic                                      awready_i,
  output logic                                      push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]         ID_o,
  input  logic                                      grant_FIFO_ID_i,
  input  logic                                      wburst_done_i,
  output logic [CNT_W-1:0]                          outstanding_o,
  output logic                                      fsm_state
);

  // Handshake: a transfer happens on the downstream AW channel in any cycle where
  // awvalid_o & awready_i; once awvalid_o rises it stays high with a frozen winner
  // until that transfer, and the transfer is the only event that pushes an ID.

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [LOG_N_TARG-1:0] LAST_IDX = LOG_N_TARG'(N_TARG_PORT - 1);

  state_t                  state_q, state_d;
  logic [LOG_N_TARG-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LOG_N_TARG-1:0]   winner_q, winner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    rr_found;
  logic [LOG_N_TARG-1:0]   rr_pick;
  logic                    eligible;
  logic [LOG_N_TARG-1:0]   cur_winner;
  logic                    grant_valid;
  logic                    handshake;
  logic [N_TARG_PORT-1:0]  onehot;

  function automatic logic [LOG_N_TARG-1:0] wrap_idx(input logic [LOG_N_TARG-1:0] base,
                                                      input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_TARG_PORT) s = s - N_TARG_PORT;
    return LOG_N_TARG'(s);
  endfunction

  // First requester at or after rr_ptr, wrapping modulo N_TARG_PORT.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (!rr_found && awvalid_i[wrap_idx(rr_ptr_q, i)]) begin
        rr_found = 1'b1;
        rr_pick  = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  assign eligible = rr_found & grant_FIFO_ID_i & (cnt_q < CNT_MAX);

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    cur_winner  = rr_pick;
    grant_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cur_winner  = rr_pick;
        grant_valid = eligible;
        if (eligible && !awready_i) begin
          state_d  = LOCKED;
          winner_d = rr_pick;
        end
      end
      LOCKED: begin
        // FIFO space and the outstanding cap cannot shrink while we hold the grant.
        cur_winner  = winner_q;
        grant_valid = 1'b1;
        if (awready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) grant_valid = 1'b0;
    handshake = grant_valid & awready_i;
    if (handshake) begin
      winner_d = cur_winner;
      rr_ptr_d = (cur_winner == LAST_IDX) ? '0 : cur_winner + 1'b1;
    end
  end

  always_comb begin
    onehot             = '0;
    onehot[cur_winner] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (handshake && !wburst_done_i) begin
      if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (!handshake && wburst_done_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign awvalid_o     = grant_valid;
  assign push_ID_o     = handshake;
  assign awready_o     = handshake ? onehot : '0;
  assign awpayload_o   = awpayload_i[cur_winner];
  assign ID_o          = {cur_winner, onehot};
  assign outstanding_o = rst ? '0 : cnt_q;
  assign fsm_state     = state_q;

endmodule
